// File: rtl/ram_master_pkg.sv
// Shared definitions for the ram_master burst controller.
//   AW_DEF / DW_DEF : default address and data widths
//   state_t         : controller state encoding
package ram_master_pkg;

  localparam int AW_DEF = 8;
  localparam int DW_DEF = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT_W  = 3'd1,
    SET_W   = 3'd2,
    PULSO_W = 3'd3,
    HOLD_W  = 3'd4,
    SET_R   = 3'd5,
    CAPT_R  = 3'd6
  } state_t;

endpackage

// File: rtl/ram_master.sv
// Burst master for a simple asynchronous-read RAM with a level-sensitive
// write enable. A host command starts a 1..16 beat read or write burst at
// an arbitrary start address; addresses wrap modulo 2^AW.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   cmd_valid/ready     command handshake (ready only in IDLE)
//   cmd_we/dir/len      burst direction, start address, length minus one
//   wdata_valid/ready   write-data handshake (ready only in WAIT_W)
//   wdata               write-data beat
//   rvalid, rdata       read beat pulse and held read data
//   done                one-cycle pulse on return to IDLE
//   direccion, Dato_E   registered RAM address and write data
//   EN                  registered RAM write enable
//   dato_s              RAM asynchronous read data
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE     | waiting for a command, cmd_ready high
// WAIT_W   | waiting for a write-data beat, wdata_ready high
// SET_W    | address/data set up at the RAM, EN low
// PULSO_W  | the single EN-high cycle of a write beat
// HOLD_W   | EN low, address/data held, then next beat or IDLE
// SET_R    | read address presented, RAM output settling
// CAPT_R   | dato_s captured into rdata at the end of the cycle
module ram_master
  import ram_master_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_we,
  input  logic [AW-1:0] cmd_dir,
  input  logic [3:0]    cmd_len,
  input  logic          wdata_valid,
  output logic          wdata_ready,
  input  logic [DW-1:0] wdata,
  output logic          rvalid,
  output logic [DW-1:0] rdata,
  output logic          done,
  output logic [AW-1:0] direccion,
  output logic [DW-1:0] Dato_E,
  output logic          EN,
  input  logic [DW-1:0] dato_s
);

  state_t        state;
  state_t        state_nxt;
  logic [AW-1:0] addr;
  logic [3:0]    cnt;
  logic          accept;
  logic          wr_hs;
  logic          beat_end;
  logic          last_beat;

  // cmd_ready is a flop that stays low until the first edge after reset,
  // so acceptance is gated by it rather than by the state alone.
  assign accept    = (state == IDLE) && cmd_valid && cmd_ready;
  assign wr_hs     = (state == WAIT_W) && wdata_valid && wdata_ready;
  assign beat_end  = (state == HOLD_W) || (state == CAPT_R);
  assign last_beat = (cnt == 4'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = cmd_we ? WAIT_W : SET_R;
        end
      end
      WAIT_W: begin
        if (wr_hs) begin
          state_nxt = SET_W;
        end
      end
      SET_W:   state_nxt = PULSO_W;
      PULSO_W: state_nxt = HOLD_W;
      HOLD_W:  state_nxt = last_beat ? IDLE : WAIT_W;
      SET_R:   state_nxt = CAPT_R;
      CAPT_R:  state_nxt = last_beat ? IDLE : SET_R;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake readies and EN are registered from the next state so they are
  // glitch-free flop outputs that line up exactly with the state they mark.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_ready   <= 1'b0;
      wdata_ready <= 1'b0;
      EN          <= 1'b0;
      rvalid      <= 1'b0;
      done        <= 1'b0;
      rdata       <= '0;
      direccion   <= '0;
      Dato_E      <= '0;
      addr        <= '0;
      cnt         <= '0;
    end else begin
      cmd_ready   <= (state_nxt == IDLE);
      wdata_ready <= (state_nxt == WAIT_W);
      EN          <= (state_nxt == PULSO_W);
      rvalid      <= 1'b0;
      done        <= 1'b0;

      if (accept) begin
        addr <= cmd_dir;
        cnt  <= cmd_len;
        if (!cmd_we) begin
          direccion <= cmd_dir;
        end
      end

      if (wr_hs) begin
        Dato_E    <= wdata;
        direccion <= addr;
      end

      if (state == CAPT_R) begin
        rdata  <= dato_s;
        rvalid <= 1'b1;
      end

      if (beat_end) begin
        if (last_beat) begin
          done <= 1'b1;
        end else begin
          cnt  <= cnt - 4'd1;
          addr <= addr + AW'(1);
          // Reads present the next address straight away; writes pick it
          // up at the next wdata handshake.
          if (state == CAPT_R) begin
            direccion <= addr + AW'(1);
          end
        end
      end
    end
  end

endmodule
